// File: rtl/lpm_lookup_client.sv
// Requester-side client for the LPM lookup engine: buffers addresses in a FIFO,
// issues one lookup at a time with a bounded wait, and returns hit/miss results.
//   state | meaning
//   IDLE  | no lookup outstanding, FIFO empty
//   ISSUE | lkp_valid strobe for the popped FIFO head
//   WAIT  | waiting for lkp_done, timer running
//   RESP  | result presented until downstream accepts it
module lpm_lookup_client #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        lkp_valid,
    output logic [31:0] lkp_addr,
    input  logic        lkp_done,
    input  logic [31:0] lkp_prefix,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_addr,
    output logic [31:0] rsp_prefix,
    output logic        rsp_hit,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t        state;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [TW-1:0] timer;
    logic          push;
    logic          pop;
    logic          not_empty;

    assign not_empty = (count != '0);
    assign req_ready = (count != CW'(DEPTH));
    assign push      = req_valid && req_ready;
    // The head leaves the FIFO on the edge that enters ISSUE, so lkp_addr is a register.
    assign pop       = not_empty && ((state == IDLE) || (state == RESP && rsp_ready));

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= req_addr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            lkp_valid  <= 1'b0;
            lkp_addr   <= '0;
            rsp_valid  <= 1'b0;
            rsp_addr   <= '0;
            rsp_prefix <= '0;
            rsp_hit    <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (not_empty) begin
                        state     <= ISSUE;
                        lkp_valid <= 1'b1;
                        lkp_addr  <= mem[rd_ptr];
                        timer     <= '0;
                    end
                end
                ISSUE, WAIT: begin
                    lkp_valid <= 1'b0;
                    timer     <= timer + TW'(1);
                    if (lkp_done) begin
                        state      <= RESP;
                        rsp_valid  <= 1'b1;
                        rsp_addr   <= lkp_addr;
                        rsp_prefix <= lkp_prefix;
                        rsp_hit    <= 1'b1;
                    end else if ((state == ISSUE && TIMEOUT == 1) ||
                                 (state == WAIT && timer == TW'(TIMEOUT - 1))) begin
                        state      <= RESP;
                        rsp_valid  <= 1'b1;
                        rsp_addr   <= lkp_addr;
                        rsp_prefix <= '0;
                        rsp_hit    <= 1'b0;
                    end else begin
                        state <= WAIT;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rsp_hit)
                            hit_count <= hit_count + 16'(hit_count != 16'hFFFF);
                        else
                            miss_count <= miss_count + 16'(miss_count != 16'hFFFF);
                        if (not_empty) begin
                            state     <= ISSUE;
                            lkp_valid <= 1'b1;
                            lkp_addr  <= mem[rd_ptr];
                            timer     <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
